// File: rtl/fft_unloader.sv
// fft_unloader: streams one frame of N_POINTS complex results from the FFT RAM through a 2-entry credit-limited buffer.
// Build option: define FFT_UNLOAD_BITREV_EN to drive scanIndex with the bit-reversed read counter.
`default_nettype none

module fft_unloader #(
  parameter int N_POINTS = 1024,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              scan,
  output logic [ADDR_W-1:0] scanIndex,
  input  logic [DATA_W-1:0] ram_real_i,
  input  logic [DATA_W-1:0] ram_imag_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N_POINTS - 1);
  localparam int                ENT_W = ADDR_W + 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic               busy_q, scan_q, done_q;
  logic [ADDR_W-1:0]  rd_cnt_q;
  logic               fl_vld_q;
  logic [ADDR_W-1:0]  fl_idx_q;
  logic [1:0]         occ_q;
  logic [ENT_W-1:0]   b0_q, b1_q;

  logic               pop;
  logic               issue;
  logic [1:0]         occ_d;
  logic [1:0]         credit;
  logic [ENT_W-1:0]   new_ent;

  // Credits count the slot freed by a same-cycle pop so a held-ready sink sees one beat per cycle.
  always_comb begin
    pop     = (occ_q != 2'd0) && out_ready;
    credit  = occ_q + {1'b0, fl_vld_q} - {1'b0, pop};
    issue   = (state_q == S_READ) && (credit < 2'd2);
    occ_d   = occ_q + {1'b0, fl_vld_q} - {1'b0, pop};
    new_ent = {fl_idx_q, ram_imag_i, ram_real_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      scan_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_cnt_q <= '0;
      fl_vld_q <= 1'b0;
      fl_idx_q <= '0;
      occ_q    <= 2'd0;
      b0_q     <= '0;
      b1_q     <= '0;
    end else begin
      fl_vld_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_READ;
            rd_cnt_q <= '0;
            busy_q   <= 1'b1;
            scan_q   <= 1'b1;
          end
        end
        S_READ: begin
          if (issue) begin
            fl_vld_q <= 1'b1;
            fl_idx_q <= rd_cnt_q;
            if (rd_cnt_q == LAST) state_q  <= S_DRAIN;
            else                  rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (occ_d == 2'd0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            scan_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      occ_q <= occ_d;
      // b0 is always the head; b1 only holds the second entry when two are buffered.
      case ({fl_vld_q, pop})
        2'b10: begin
          if (occ_q == 2'd0) b0_q <= new_ent;
          else               b1_q <= new_ent;
        end
        2'b01: b0_q <= b1_q;
        2'b11: begin
          if (occ_q == 2'd1) begin
            b0_q <= new_ent;
          end else begin
            b0_q <= b1_q;
            b1_q <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FFT_UNLOAD_BITREV_EN
  for (genvar i = 0; i < ADDR_W; i++) begin : g_bitrev
    assign scanIndex[i] = rd_cnt_q[ADDR_W-1-i];
  end
`else
  assign scanIndex = rd_cnt_q;
`endif

  assign busy      = busy_q;
  assign scan      = scan_q;
  assign done      = done_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_real  = b0_q[DATA_W-1:0];
  assign out_imag  = b0_q[2*DATA_W-1:DATA_W];
  assign out_index = b0_q[ENT_W-1:2*DATA_W];
  assign out_last  = out_valid && (b0_q[ENT_W-1:2*DATA_W] == LAST);

endmodule

`default_nettype wire

// File: tb/tb_fft_unloader.sv
// tb_fft_unloader: randomized frame unloading checked against a beat-level reference model.
`default_nettype none

module tb_fft_unloader;

  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, scan, out_valid, out_last;
  logic [AW-1:0] scanIndex, out_index;
  logic [DW-1:0] out_real, out_imag;
  logic [DW-1:0] ram_re = '0, ram_im = '0;
  logic [DW-1:0] mem_re [N];
  logic [DW-1:0] mem_im [N];

  fft_unloader #(.N_POINTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .scan(scan),
    .scanIndex(scanIndex), .ram_real_i(ram_re), .ram_imag_i(ram_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real),
    .out_imag(out_imag), .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_re <= mem_re[scanIndex];
    ram_im <= mem_im[scanIndex];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM address holding frequency bin j.
  function automatic int addr_of(input int j);
`ifdef FFT_UNLOAD_BITREV_EN
    int r = 0;
    for (int b = 0; b < AW; b++) if (j[b]) r |= 1 << (AW - 1 - b);
    return r;
`else
    return j;
`endif
  endfunction

  int  rdy_mode = 0;
  int  ptr = 0;
  bit  frame_on = 0, busy_exp = 0, done_exp = 0, idle_exp = 1;
  int  cyc = 0, frames_done = 0;
  int  start_cyc = 0, first_valid_cyc = -1, last_hs_cyc = 0;
  logic [DW-1:0] cap_re1 = '0, cap_re3 = '0, cap_im1 = '0;

  always @(negedge clk) begin
    bit r, hs, nd;
    int a;
    cyc++;
    if (!rst) begin
      ptr = 0; frame_on = 0; busy_exp = 0; done_exp = 0; idle_exp = 1;
    end else begin
      chk("busy", busy, busy_exp);
      chk("scan", scan, busy_exp);
      chk("done", done, done_exp);
      if (done) frames_done++;
      if (out_valid) begin
        if (!frame_on || ptr >= N) begin
          chk("spurious_valid", 1, 0);
        end else begin
          a = addr_of(ptr);
          chk("out_index", out_index, ptr);
          chk("out_real", out_real, mem_re[a]);
          chk("out_imag", out_imag, mem_im[a]);
          chk("out_last", out_last, ptr == N - 1);
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (ptr == 1) begin cap_re1 = out_real; cap_im1 = out_imag; end
          if (ptr == 3) cap_re3 = out_real;
        end
      end
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = 1'b0;
      endcase
      out_ready = r;
      hs = out_valid && r && frame_on && ptr < N;
      nd = hs && (ptr == N - 1);
      if (start && idle_exp) begin
        busy_exp = 1; idle_exp = 0; frame_on = 1; ptr = 0;
        start_cyc = cyc; first_valid_cyc = -1;
      end else if (done_exp) begin
        idle_exp = 1;
      end
      if (hs) begin ptr++; last_hs_cyc = cyc; end
      done_exp = nd;
      if (nd) begin busy_exp = 0; frame_on = 0; end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_frame();
    int n0 = frames_done;
    int t  = 0;
    while (frames_done == n0 && t < 6000) begin @(posedge clk); t++; end
    if (t >= 6000) chk("frame_timeout", 0, 1);
    repeat (20) @(posedge clk);
    chk("single_done", frames_done, n0 + 1);
  endtask

  task automatic wait_ptr(input int p);
    int t = 0;
    while (ptr < p && t < 6000) begin @(posedge clk); t++; end
    if (t >= 6000) chk("ptr_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_scan", scan, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_scanIndex", scanIndex, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_real", out_real, 0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      mem_re[k] = $urandom;
      mem_im[k] = $urandom;
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      mem_re[k] = 32'h0000_0000 + k;
      mem_im[k] = 32'hFFFF_0000 + k;
    end
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst = 1'b1;

    // Frame 1: ready held high, ramp pattern
    rdy_mode = 0;
    pulse_start();
    wait_frame();
    chk("first_valid_latency", first_valid_cyc - start_cyc, 3);
    chk("back_to_back", last_hs_cyc - start_cyc, 3 + N - 1);
`ifdef FFT_UNLOAD_BITREV_EN
    chk("bin1_real", cap_re1, 32'd512);
    chk("bin1_imag", cap_im1, 32'hFFFF_0200);
    chk("bin3_real", cap_re3, 32'd768);
`else
    chk("bin1_real", cap_re1, 32'd1);
    chk("bin1_imag", cap_im1, 32'hFFFF_0001);
    chk("bin3_real", cap_re3, 32'd3);
`endif

    // Frame 2: random backpressure, extra start while busy
    fill_random();
    rdy_mode = 1;
    pulse_start();
    wait_ptr(100);
    pulse_start();
    wait_frame();

    // Frame 3: reset mid-frame, then a fresh frame from bin 0
    fill_random();
    pulse_start();
    wait_ptr(500);
    @(posedge clk); #1 rst = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    pulse_start();
    wait_frame();

    // Frame 4: sink stalled for 50 cycles
    fill_random();
    rdy_mode = 2;
    pulse_start();
    repeat (50) @(posedge clk);
    #1;
    chk("stall_valid", out_valid, 1);
    chk("stall_index", out_index, 0);
    chk("stall_reads", scanIndex, addr_of(2));
    rdy_mode = 0;
    wait_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_unloader.md
FFT_UNLOADER -- requirements
Module: fft_unloader

Interface
REQ-001 SHALL have parameter N_POINTS, default 1024, number of complex results per frame.
REQ-002 SHALL have parameter ADDR_W, default 10, RAM index width (log2 N_POINTS).
REQ-003 SHALL have parameter DATA_W, default 32, width of each real/imag word.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to unload one frame.
REQ-007 busy  out  1  high from the cycle after start is accepted until done.
REQ-008 done  out  1  one-cycle pulse when frame fully delivered.
REQ-009 scan  out  1  selects unloader index on RAM port A mux.
REQ-010 scanIndex  out  ADDR_W  RAM read address.
REQ-011 ram_real_i  in  DATA_W  RAM port A real data, 1-cycle synchronous read.
REQ-012 ram_imag_i  in  DATA_W  RAM port A imag data.
REQ-013 out_valid  out  1  result beat available.
REQ-014 out_ready  in  1  sink accepts beat; transfer when valid&&ready.
REQ-015 out_real / out_imag  out  DATA_W each  result data.
REQ-016 out_index  out  ADDR_W  frequency-bin number of current beat.
REQ-017 out_last  out  1  high on beat with out_index == N_POINTS-1.

Function
REQ-018 FSM states IDLE, READ, DRAIN, DONE; SHALL move IDLE->READ on start, READ->DRAIN after issuing read N_POINTS-1, DRAIN->DONE when buffer empty and no read in flight, DONE->IDLE unconditionally.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 scan SHALL be high exactly in READ and DRAIN.
REQ-021 Reads SHALL be credit-limited: issue only when (buffer occupancy + reads in flight) < 2; 2-entry output buffer, never overflows.
REQ-022 Read counter SHALL increment by one per issued read, 0..N_POINTS-1, no wrap within frame.
REQ-023 Data SHALL be captured into the buffer one cycle after its read issue.
REQ-024 First out_valid SHALL assert 2 cycles after the edge sampling start.
REQ-025 With out_ready held high, SHALL deliver one beat per cycle, N_POINTS consecutive beats.
REQ-026 out_valid SHALL stay high and out_real/out_imag/out_index/out_last SHALL stay stable until accepted.
REQ-027 Simultaneous buffer push and pop SHALL keep occupancy unchanged, order preserved.
REQ-028 done SHALL pulse the cycle after the out_last handshake; busy SHALL fall with it.
REQ-029 Data SHALL pass unmodified (no scaling, no rounding).

Reset
REQ-030 On rst low, SHALL go to IDLE immediately; busy, done, scan, out_valid, out_last = 0; scanIndex, out_index, counters, buffer = 0.
REQ-031 Reset mid-frame SHALL discard in-flight and buffered data; next start begins at bin 0.

Configuration
REQ-032 Macro FFT_UNLOAD_BITREV_EN: when defined, scanIndex SHALL be the ADDR_W-bit bit-reverse of the read counter (natural-order output from bit-reversed RAM); when undefined, scanIndex SHALL equal the read counter.
REQ-033 out_index SHALL equal the read counter value of the beat in both configurations.

Verification
REQ-034 RAM preloaded word k = real 0x0000_0000+k, imag 0xFFFF_0000+k, out_ready=1, start -> 1024 beats back-to-back, out_index 0..1023, out_last only at 1023, done one cycle later.
REQ-035 FFT_UNLOAD_BITREV_EN defined, same RAM -> beat with out_index 1 carries RAM word 512, out_index 3 carries word 768.
REQ-036 out_ready toggled pseudo-randomly (50%) -> no lost/duplicated beats, payload stable while valid&&!ready, max 2 buffered.
REQ-037 start pulsed again while busy at beat 100 -> ignored, single frame of 1024 beats, one done.
REQ-038 rst low at beat 500, released, start -> all outputs 0 during reset, new frame starts at out_index 0.
REQ-039 out_ready held 0 for 50 cycles after start -> exactly 2 reads issued, out_valid held with out_index 0.
